// File: rtl/branch_resolver_if.sv
// Predictor/execute-facing handshake bundle for branch_resolver.
// The resolver owns the slave view; the driving environment owns the master view.
interface branch_resolver_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             upd_request;
    logic             upd_taken;
    logic             mispredict;
    logic             res_error;
    logic [OW-1:0]    occupancy;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [CNT_W-1:0] resolve_cnt;

    modport master (
        output pred_valid, pred_taken, res_valid, res_taken,
        input  pred_ready, upd_request, upd_taken, mispredict,
        input  res_error, occupancy, mispredict_cnt, resolve_cnt
    );

    modport slave (
        input  pred_valid, pred_taken, res_valid, res_taken,
        output pred_ready, upd_request, upd_taken, mispredict,
        output res_error, occupancy, mispredict_cnt, resolve_cnt
    );
endinterface

// File: rtl/branch_resolver.sv
// In-order queue of predictions matched against execute-stage outcomes;
// trains the predictor, flags mispredicts and flushes the wrong path.
module branch_resolver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic         clk,
    input logic         rst_n,
    branch_resolver_if.slave br
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [OW-1:0]    count;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic miss;
    logic err;

    logic             upd_request_q;
    logic             upd_taken_q;
    logic             mispredict_q;
    logic             res_error_q;
    logic [CNT_W-1:0] mis_cnt_q;
    logic [CNT_W-1:0] res_cnt_q;

    always_comb begin
        full  = (count == OW'(DEPTH));
        empty = (count == '0);
        push  = br.pred_valid && !full;
        pop   = br.res_valid && !empty;
        miss  = pop && (mem[head] != br.res_taken);
        err   = br.res_valid && empty;
    end

    // A mispredict drops everything younger, including a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (miss) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= br.pred_taken;
                tail      <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_request_q <= 1'b0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            res_error_q   <= 1'b0;
        end else begin
            upd_request_q <= pop;
            mispredict_q  <= miss;
            res_error_q   <= err;
            if (pop) begin
                upd_taken_q <= br.res_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (pop && (res_cnt_q != '1)) begin
                res_cnt_q <= res_cnt_q + CNT_W'(1);
            end
            if (miss && (mis_cnt_q != '1)) begin
                mis_cnt_q <= mis_cnt_q + CNT_W'(1);
            end
        end
    end

    assign br.pred_ready     = !full;
    assign br.occupancy      = count;
    assign br.upd_request    = upd_request_q;
    assign br.upd_taken      = upd_taken_q;
    assign br.mispredict     = mispredict_q;
    assign br.res_error      = res_error_q;
    assign br.mispredict_cnt = mis_cnt_q;
    assign br.resolve_cnt    = res_cnt_q;

    a_mis_upd : assert property (
        @(posedge clk) disable iff (!rst_n)
        mispredict_q |-> upd_request_q
    );

    a_err_excl : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(res_error_q && upd_request_q)
    );

    a_occ_max : assert property (
        @(posedge clk) disable iff (!rst_n)
        count <= OW'(DEPTH)
    );
endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench: one default-width resolver and one with 2-bit counters,
// both fed the same stimulus.
module tb_branch_resolver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pv = 1'b0;
    logic pt = 1'b0;
    logic rv = 1'b0;
    logic rt = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    bit q[$];
    bit e;

    always #5 clk = ~clk;

    branch_resolver_if #(.DEPTH(4), .CNT_W(16)) b16 ();
    branch_resolver_if #(.DEPTH(4), .CNT_W(2))  b2 ();

    assign b16.pred_valid = pv;
    assign b16.pred_taken = pt;
    assign b16.res_valid  = rv;
    assign b16.res_taken  = rt;
    assign b2.pred_valid  = pv;
    assign b2.pred_taken  = pt;
    assign b2.res_valid   = rv;
    assign b2.res_taken   = rt;

    branch_resolver #(.DEPTH(4), .CNT_W(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .br    (b16)
    );

    branch_resolver #(.DEPTH(4), .CNT_W(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .br    (b2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input string tag, input bit req, input bit mis,
                          input bit er);
        check({tag, ".upd_request"}, 32'(b16.upd_request), 32'(req));
        check({tag, ".mispredict"}, 32'(b16.mispredict), 32'(mis));
        check({tag, ".res_error"}, 32'(b16.res_error), 32'(er));
    endtask

    task automatic push(input bit t);
        pv = 1'b1;
        pt = t;
        rv = 1'b0;
        step();
        pv = 1'b0;
    endtask

    initial begin
        #1;
        check("rst.occ", 32'(b16.occupancy), 32'd0);
        check("rst.ready", 32'(b16.pred_ready), 32'd1);
        pulses("rst", 1'b0, 1'b0, 1'b0);
        check("rst.upd_taken", 32'(b16.upd_taken), 32'd0);
        check("rst.rcnt", 32'(b16.resolve_cnt), 32'd0);
        check("rst.mcnt", 32'(b16.mispredict_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        push(1'b1);
        push(1'b0);
        push(1'b1);
        step();
        check("p3.occ", 32'(b16.occupancy), 32'd3);
        check("p3.ready", 32'(b16.pred_ready), 32'd1);
        pulses("p3", 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        check("rst2.occ", 32'(b16.occupancy), 32'd0);

        push(1'b1);
        rv = 1'b1;
        rt = 1'b1;
        step();
        rv = 1'b0;
        pulses("ok", 1'b1, 1'b0, 1'b0);
        check("ok.upd_taken", 32'(b16.upd_taken), 32'd1);
        check("ok.rcnt", 32'(b16.resolve_cnt), 32'd1);
        check("ok.occ", 32'(b16.occupancy), 32'd0);
        step();
        pulses("ok.after", 1'b0, 1'b0, 1'b0);
        check("ok.hold", 32'(b16.upd_taken), 32'd1);

        push(1'b1);
        push(1'b0);
        push(1'b0);
        check("mp.pre_occ", 32'(b16.occupancy), 32'd3);
        pv = 1'b1;
        pt = 1'b1;
        rv = 1'b1;
        rt = 1'b0;
        step();
        pv = 1'b0;
        rv = 1'b0;
        pulses("mp", 1'b1, 1'b1, 1'b0);
        check("mp.upd_taken", 32'(b16.upd_taken), 32'd0);
        check("mp.occ", 32'(b16.occupancy), 32'd0);
        check("mp.mcnt", 32'(b16.mispredict_cnt), 32'd1);
        check("mp.rcnt", 32'(b16.resolve_cnt), 32'd2);

        rv = 1'b1;
        rt = 1'b1;
        step();
        rv = 1'b0;
        pulses("empty", 1'b0, 1'b0, 1'b1);
        check("empty.rcnt", 32'(b16.resolve_cnt), 32'd2);
        check("empty.hold", 32'(b16.upd_taken), 32'd0);
        step();
        pulses("empty.after", 1'b0, 1'b0, 1'b0);

        q = {};
        push(1'b1); q.push_back(1'b1);
        push(1'b0); q.push_back(1'b0);
        push(1'b1); q.push_back(1'b1);
        push(1'b1); q.push_back(1'b1);
        check("full.ready", 32'(b16.pred_ready), 32'd0);
        push(1'b1);
        check("full.occ", 32'(b16.occupancy), 32'd4);

        pv = 1'b1;
        pt = 1'b0;
        rv = 1'b1;
        e  = q.pop_front();
        rt = e;
        step();
        pv = 1'b0;
        rv = 1'b0;
        pulses("full.res", 1'b1, 1'b0, 1'b0);
        check("full.res.taken", 32'(b16.upd_taken), 32'(e));
        check("full.res.occ", 32'(b16.occupancy), 32'd3);

        for (int i = 0; i < 8; i++) begin
            pv = 1'b1;
            pt = ((i % 3) == 1);
            q.push_back(pt);
            rv = 1'b1;
            e  = q.pop_front();
            rt = e;
            step();
            check($sformatf("wrap%0d.taken", i),
                  32'(b16.upd_taken), 32'(e));
            check($sformatf("wrap%0d.req", i),
                  32'(b16.upd_request), 32'd1);
            check($sformatf("wrap%0d.mis", i),
                  32'(b16.mispredict), 32'd0);
            check($sformatf("wrap%0d.occ", i),
                  32'(b16.occupancy), 32'd3);
        end
        pv = 1'b0;
        rv = 1'b0;
        check("wrap.rcnt", 32'(b16.resolve_cnt), 32'd11);
        check("wrap.mcnt", 32'(b16.mispredict_cnt), 32'd1);
        check("wrap.rcnt2", 32'(b2.resolve_cnt), 32'd3);

        rv = 1'b1;
        rt = !q[0];
        step();
        rv = 1'b0;
        q = {};
        check("sat0.mis", 32'(b16.mispredict), 32'd1);
        check("sat0.occ", 32'(b16.occupancy), 32'd0);
        for (int i = 1; i < 5; i++) begin
            push(1'b1);
            rv = 1'b1;
            rt = 1'b0;
            step();
            rv = 1'b0;
            check($sformatf("sat%0d.mis", i),
                  32'(b16.mispredict), 32'd1);
        end
        check("sat.mcnt16", 32'(b16.mispredict_cnt), 32'd6);
        check("sat.mcnt2", 32'(b2.mispredict_cnt), 32'd3);
        check("sat.rcnt16", 32'(b16.resolve_cnt), 32'd16);
        check("sat.rcnt2", 32'(b2.resolve_cnt), 32'd3);

        push(1'b1);
        push(1'b0);
        check("arst.pre_occ", 32'(b16.occupancy), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.occ", 32'(b16.occupancy), 32'd0);
        check("arst.ready", 32'(b16.pred_ready), 32'd1);
        check("arst.mcnt", 32'(b16.mispredict_cnt), 32'd0);
        check("arst.rcnt", 32'(b16.resolve_cnt), 32'd0);
        check("arst.mcnt2", 32'(b2.mispredict_cnt), 32'd0);
        check("arst.taken", 32'(b16.upd_taken), 32'd0);
        pulses("arst", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
